ysyx_22040750_clint: RTL and testbench



---
 rtl/ysyx_22040750_clint.sv | 215 +++++++++++++++++++++
 tb/tb_ysyx_22040750_clint.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-beat AXI4-Lite slave port.
// Read and write channels run independent two-state FSMs; O_mtip is a compare of the live registers.
module ysyx_22040750_clint #(
    parameter int unsigned TICK_DIV = 1,
    parameter logic [31:0] BASE     = 32'h0200_0000
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_araddr,
    input  logic        I_arvalid,
    output logic        O_arready,
    output logic [63:0] O_rdata,
    output logic        O_rvalid,
    input  logic        I_rready,
    input  logic [31:0] I_awaddr,
    input  logic        I_awvalid,
    output logic        O_awready,
    input  logic [63:0] I_wdata,
    input  logic [7:0]  I_wstrb,
    input  logic        I_wvalid,
    output logic        O_wready,
    output logic        O_bvalid,
    input  logic        I_bready,
    output logic        O_mtip,
    output logic        O_msip
);

    localparam logic [28:0] IDX_MSIP     = 29'h0000000;
    localparam logic [28:0] IDX_MTIMECMP = 29'h0000800;
    localparam logic [28:0] IDX_MTIME    = 29'h00017FF;
    localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);

    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;
    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
            else         res[i*8 +: 8] = old_val[i*8 +: 8];
        end
        return res;
    endfunction

    r_state_t    r_state_r, r_state_s;
    w_state_t    w_state_r, w_state_s;
    logic [63:0] rdata_r;
    logic        aw_got_r, w_got_r;
    logic [31:0] awaddr_r;
    logic [63:0] wdata_r;
    logic [7:0]  wstrb_r;
    logic [15:0] presc_r;
    logic [63:0] mtime_r, mtimecmp_r;
    logic        msip_r;

    logic        tick_s;
    logic [63:0] mtime_inc_s, mtime_nxt_s, mtimecmp_nxt_s;
    logic        msip_nxt_s;
    logic        ar_fire_s, aw_fire_s, w_fire_s, commit_s;
    logic [31:0] rd_off_s, wr_addr_s, wr_off_s;
    logic [63:0] wr_data_s, rd_val_s;
    logic [7:0]  wr_strb_s;
    logic        addr_lsb_unused_s;

    assign O_arready = (r_state_r == R_IDLE);
    assign O_rvalid  = (r_state_r == R_RESP);
    assign O_rdata   = rdata_r;
    assign O_awready = (w_state_r == W_IDLE) && !aw_got_r;
    assign O_wready  = (w_state_r == W_IDLE) && !w_got_r;
    assign O_bvalid  = (w_state_r == W_RESP);
    assign O_mtip    = (mtime_r >= mtimecmp_r);
    assign O_msip    = msip_r;

    assign tick_s      = (presc_r == TICK_LAST);
    assign mtime_inc_s = tick_s ? (mtime_r + 64'd1) : mtime_r;

    assign ar_fire_s = O_arready && I_arvalid;
    assign aw_fire_s = O_awready && I_awvalid;
    assign w_fire_s  = O_wready && I_wvalid;
    // A write commits once both halves are either held or arriving this cycle
    assign commit_s  = (w_state_r == W_IDLE) && (aw_got_r || aw_fire_s) && (w_got_r || w_fire_s);

    assign wr_addr_s = aw_got_r ? awaddr_r : I_awaddr;
    assign wr_data_s = w_got_r ? wdata_r : I_wdata;
    assign wr_strb_s = w_got_r ? wstrb_r : I_wstrb;
    assign rd_off_s  = I_araddr - BASE;
    assign wr_off_s  = wr_addr_s - BASE;
    assign addr_lsb_unused_s = ^{rd_off_s[2:0], wr_off_s[2:0]};

    // Read-side register decode
    always_comb begin
        rd_val_s = 64'd0;
        case (rd_off_s[31:3])
            IDX_MSIP:     rd_val_s = {63'd0, msip_r};
            IDX_MTIMECMP: rd_val_s = mtimecmp_r;
            IDX_MTIME:    rd_val_s = mtime_r;
            default:      rd_val_s = 64'd0;
        endcase
    end

    // Register next values: written bytes override the ticked mtime
    always_comb begin
        mtime_nxt_s    = mtime_inc_s;
        mtimecmp_nxt_s = mtimecmp_r;
        msip_nxt_s     = msip_r;
        if (commit_s) begin
            case (wr_off_s[31:3])
                IDX_MTIME:    mtime_nxt_s    = merge_bytes(mtime_inc_s, wr_data_s, wr_strb_s);
                IDX_MTIMECMP: mtimecmp_nxt_s = merge_bytes(mtimecmp_r, wr_data_s, wr_strb_s);
                IDX_MSIP: begin
                    if (wr_strb_s[0]) msip_nxt_s = wr_data_s[0];
                    else              msip_nxt_s = msip_r;
                end
                default:      msip_nxt_s = msip_r;
            endcase
        end else begin
            msip_nxt_s = msip_r;
        end
    end

    // Read FSM next state
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_fire_s) r_state_s = R_RESP;
                else           r_state_s = R_IDLE;
            end
            R_RESP: begin
                if (I_rready) r_state_s = R_IDLE;
                else          r_state_s = R_RESP;
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Write FSM next state
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (commit_s) w_state_s = W_RESP;
                else          w_state_s = W_IDLE;
            end
            W_RESP: begin
                if (I_bready) w_state_s = W_IDLE;
                else          w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Read channel state and captured data
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state_r <= R_IDLE;
            rdata_r   <= 64'd0;
        end else begin
            r_state_r <= r_state_s;
            if (ar_fire_s) rdata_r <= rd_val_s;
        end
    end

    // Write channel state and AW/W holding registers
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            w_state_r <= W_IDLE;
            aw_got_r  <= 1'b0;
            w_got_r   <= 1'b0;
            awaddr_r  <= 32'd0;
            wdata_r   <= 64'd0;
            wstrb_r   <= 8'd0;
        end else begin
            w_state_r <= w_state_s;
            if ((w_state_r == W_RESP) && I_bready) begin
                aw_got_r <= 1'b0;
                w_got_r  <= 1'b0;
            end else begin
                if (aw_fire_s) begin
                    aw_got_r <= 1'b1;
                    awaddr_r <= I_awaddr;
                end
                if (w_fire_s) begin
                    w_got_r <= 1'b1;
                    wdata_r <= I_wdata;
                    wstrb_r <= I_wstrb;
                end
            end
        end
    end

    // Prescaler wraps at TICK_DIV-1; software writes never disturb it
    always_ff @(posedge I_clk) begin
        if (I_rst)       presc_r <= 16'd0;
        else if (tick_s) presc_r <= 16'd0;
        else             presc_r <= presc_r + 16'd1;
    end

    // Timer and software-interrupt registers
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            mtime_r    <= 64'd0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_r     <= 1'b0;
        end else begin
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= mtimecmp_nxt_s;
            msip_r     <= msip_nxt_s;
        end
    end

endmodule

// File: tb/tb_ysyx_22040750_clint.sv
// Directed-plus-random bench for the CLINT; two instances (TICK_DIV=1 and 4) share all inputs
// and are checked against a cycle-level arithmetic model of the timer and registers.
module tb_ysyx_22040750_clint;

    localparam logic [31:0] BASE   = 32'h0200_0000;
    localparam logic [31:0] A_MSIP = 32'h0200_0000;
    localparam logic [31:0] A_CMP  = 32'h0200_4000;
    localparam logic [31:0] A_MT   = 32'h0200_BFF8;
    localparam logic [31:0] A_NONE = 32'h0200_0100;

    logic        clk;
    logic        I_rst;
    logic [31:0] I_araddr, I_awaddr;
    logic        I_arvalid, I_rready, I_awvalid, I_wvalid, I_bready;
    logic [63:0] I_wdata;
    logic [7:0]  I_wstrb;

    logic        arready1, rvalid1, awready1, wready1, bvalid1, mtip1, msip1;
    logic [63:0] rdata1;
    logic        arready4, rvalid4, awready4, wready4, bvalid4, mtip4, msip4;
    logic [63:0] rdata4;

    ysyx_22040750_clint #(.TICK_DIV(1), .BASE(BASE)) dut1 (
        .I_clk(clk), .I_rst(I_rst),
        .I_araddr(I_araddr), .I_arvalid(I_arvalid), .O_arready(arready1),
        .O_rdata(rdata1), .O_rvalid(rvalid1), .I_rready(I_rready),
        .I_awaddr(I_awaddr), .I_awvalid(I_awvalid), .O_awready(awready1),
        .I_wdata(I_wdata), .I_wstrb(I_wstrb), .I_wvalid(I_wvalid), .O_wready(wready1),
        .O_bvalid(bvalid1), .I_bready(I_bready), .O_mtip(mtip1), .O_msip(msip1)
    );

    ysyx_22040750_clint #(.TICK_DIV(4), .BASE(BASE)) dut4 (
        .I_clk(clk), .I_rst(I_rst),
        .I_araddr(I_araddr), .I_arvalid(I_arvalid), .O_arready(arready4),
        .O_rdata(rdata4), .O_rvalid(rvalid4), .I_rready(I_rready),
        .I_awaddr(I_awaddr), .I_awvalid(I_awvalid), .O_awready(awready4),
        .I_wdata(I_wdata), .I_wstrb(I_wstrb), .I_wvalid(I_wvalid), .O_wready(wready4),
        .O_bvalid(bvalid4), .I_bready(I_bready), .O_mtip(mtip4), .O_msip(msip4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: what the registers should hold right now
    logic [63:0] m_mt1, m_mt4, m_cmp;
    logic        m_msip;
    int          m_cyc;
    logic        m_pend;
    logic [31:0] m_waddr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lanes(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++)
            if (s[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mread(input logic [31:0] a, input bit four);
        logic [31:0] off;
        off = (a - BASE) & ~32'd7;
        case (off)
            32'h0000_0000: return {63'd0, m_msip};
            32'h0000_4000: return m_cmp;
            32'h0000_BFF8: return four ? m_mt4 : m_mt1;
            default:       return 64'd0;
        endcase
    endfunction

    // One clock: advance the model across the posedge, then check interrupts at the negedge
    task automatic tick();
        logic [63:0] n1, n4;
        logic [31:0] off;
        @(posedge clk);
        if (I_rst) begin
            m_mt1 = 64'd0; m_mt4 = 64'd0; m_cmp = '1; m_msip = 1'b0; m_cyc = 0; m_pend = 1'b0;
        end else begin
            n1 = m_mt1 + 64'd1;
            n4 = (m_cyc % 4 == 3) ? m_mt4 + 64'd1 : m_mt4;
            m_cyc++;
            if (m_pend) begin
                off = (m_waddr - BASE) & ~32'd7;
                case (off)
                    32'h0000_BFF8: begin n1 = lanes(n1, m_wdata, m_wstrb); n4 = lanes(n4, m_wdata, m_wstrb); end
                    32'h0000_4000: m_cmp = lanes(m_cmp, m_wdata, m_wstrb);
                    32'h0000_0000: if (m_wstrb[0]) m_msip = m_wdata[0];
                    default: ;
                endcase
                m_pend = 1'b0;
            end
            m_mt1 = n1;
            m_mt4 = n4;
        end
        @(negedge clk);
        chk("mtip1", {63'd0, mtip1}, {63'd0, m_mt1 >= m_cmp});
        chk("mtip4", {63'd0, mtip4}, {63'd0, m_mt4 >= m_cmp});
        chk("msip1", {63'd0, msip1}, {63'd0, m_msip});
        chk("msip4", {63'd0, msip4}, {63'd0, m_msip});
    endtask

    task automatic do_read(input logic [31:0] a, input int rhold,
                           output logic [63:0] got1, output logic [63:0] got4);
        logic [63:0] e1, e4;
        e1 = mread(a, 1'b0);
        e4 = mread(a, 1'b1);
        I_araddr = a; I_arvalid = 1'b1;
        tick();
        I_arvalid = 1'b0;
        chk("rvalid_after_ar", {63'd0, rvalid1 & rvalid4}, 64'd1);
        chk("arready_busy", {63'd0, arready1 | arready4}, 64'd0);
        chk("rdata1", rdata1, e1);
        chk("rdata4", rdata4, e4);
        got1 = rdata1;
        got4 = rdata4;
        for (int i = 0; i < rhold; i++) begin
            tick();
            chk("rvalid_hold", {63'd0, rvalid1}, 64'd1);
            chk("rdata_hold", rdata1, e1);
        end
        I_rready = 1'b1;
        tick();
        I_rready = 1'b0;
        chk("rvalid_cleared", {63'd0, rvalid1 | rvalid4}, 64'd0);
        chk("arready_back", {63'd0, arready1 & arready4}, 64'd1);
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first
    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int order, input int bhold);
        I_awaddr = a; I_wdata = d; I_wstrb = s;
        m_waddr = a; m_wdata = d; m_wstrb = s;
        if (order == 1) begin
            I_awvalid = 1'b1;
            tick();
            I_awvalid = 1'b0;
            I_awaddr = 32'hDEAD_BEE8;
            chk("awfirst_bvalid", {63'd0, bvalid1}, 64'd0);
            chk("awfirst_ready", {62'd0, awready1, wready1}, 64'd1);
        end else if (order == 2) begin
            I_wvalid = 1'b1;
            tick();
            I_wvalid = 1'b0;
            I_wdata = ~d; I_wstrb = ~s;
            chk("wfirst_bvalid", {63'd0, bvalid1}, 64'd0);
            chk("wfirst_ready", {62'd0, awready1, wready1}, 64'd2);
        end
        I_awvalid = (order != 1);
        I_wvalid  = (order != 2);
        m_pend = 1'b1;
        tick();
        I_awvalid = 1'b0; I_wvalid = 1'b0;
        chk("bvalid_after_commit", {62'd0, bvalid1, bvalid4}, 64'd3);
        chk("ready_low_in_resp", {62'd0, awready1, wready1}, 64'd0);
        for (int i = 0; i < bhold; i++) begin
            tick();
            chk("bvalid_hold", {63'd0, bvalid1}, 64'd1);
            chk("ready_hold_low", {62'd0, awready1, wready1}, 64'd0);
        end
        I_bready = 1'b1;
        tick();
        I_bready = 1'b0;
        chk("bvalid_cleared", {62'd0, bvalid1, bvalid4}, 64'd0);
        chk("ready_back", {60'd0, awready1, wready1, awready4, wready4}, 64'hF);
    endtask

    logic [63:0] r1a, r4a, r1b, r4b, rnd;
    logic [31:0] addrs [5];

    initial begin
        addrs[0] = A_MSIP; addrs[1] = A_CMP; addrs[2] = A_MT; addrs[3] = A_NONE; addrs[4] = A_MT + 32'd4;
        I_rst = 1'b1; I_araddr = 32'd0; I_arvalid = 1'b0; I_rready = 1'b0;
        I_awaddr = 32'd0; I_awvalid = 1'b0; I_wvalid = 1'b0; I_wdata = 64'd0; I_wstrb = 8'd0;
        I_bready = 1'b0;
        m_pend = 1'b0;
        @(negedge clk);
        tick();
        tick();
        I_rst = 1'b0;

        // Reset state
        chk("rst_ready", {61'd0, arready1, awready1, wready1}, 64'd7);
        chk("rst_valid", {62'd0, rvalid1, bvalid1}, 64'd0);
        chk("rst_rdata", rdata1, 64'd0);
        chk("rst_irq", {62'd0, mtip1, msip1}, 64'd0);

        // mtime readback: second AR five cycles after the first
        repeat (8) tick();
        do_read(A_MT, 0, r1a, r4a);
        repeat (3) tick();
        do_read(A_MT, 0, r1b, r4b);
        chk("mtime_delta5", r1b - r1a, 64'd5);
        do_read(A_MT, 0, r1a, r4a);
        repeat (2) tick();
        do_read(A_MT, 0, r1b, r4b);
        chk("mtime_div4_delta", r4b - r4a, 64'd1);
        do_read(A_MT + 32'd4, 1, r1a, r4a);

        // Timer compare crossing and drop
        do_write(A_CMP, 64'd100, 8'hFF, 0, 0);
        do_write(A_MT, 64'd90, 8'hFF, 1, 0);
        chk("mtip_below", {63'd0, mtip1}, 64'd0);
        for (int i = 0; i < 40 && m_mt1 < 64'd100; i++) tick();
        chk("mtip_reached", {63'd0, mtip1}, 64'd1);
        do_write(A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2, 3);
        chk("mtip_dropped", {63'd0, mtip1}, 64'd0);

        // Software interrupt bit
        do_write(A_MSIP, 64'd1, 8'h01, 0, 0);
        chk("msip_set", {63'd0, msip1}, 64'd1);
        do_write(A_MSIP, 64'd0, 8'h02, 1, 1);
        chk("msip_kept", {63'd0, msip1}, 64'd1);
        do_read(A_MSIP, 0, r1a, r4a);
        chk("msip_read", r1a, 64'd1);

        // Partial mtime write on a tick cycle
        rnd = {$urandom, $urandom};
        do_write(A_MT, rnd, 8'h0F, 0, 0);
        do_read(A_MT, 0, r1a, r4a);

        // Reset while both responses are pending
        I_araddr = A_CMP; I_arvalid = 1'b1;
        I_awaddr = A_MSIP; I_wdata = 64'd0; I_wstrb = 8'h01; I_awvalid = 1'b1; I_wvalid = 1'b1;
        m_waddr = A_MSIP; m_wdata = 64'd0; m_wstrb = 8'h01; m_pend = 1'b1;
        tick();
        I_arvalid = 1'b0; I_awvalid = 1'b0; I_wvalid = 1'b0;
        chk("pending_both", {62'd0, rvalid1, bvalid1}, 64'd3);
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        chk("midrst_valid", {60'd0, rvalid1, bvalid1, rvalid4, bvalid4}, 64'd0);
        chk("midrst_ready", {61'd0, arready1, awready1, wready1}, 64'd7);
        chk("midrst_rdata", rdata1, 64'd0);

        // Unmapped window
        do_read(A_NONE, 0, r1a, r4a);
        chk("unmapped_read", r1a, 64'd0);
        do_write(A_NONE, {$urandom, $urandom}, 8'hFF, 0, 0);
        do_read(A_CMP, 0, r1a, r4a);
        do_read(A_MSIP, 0, r1a, r4a);

        // Randomised traffic
        for (int k = 0; k < 24; k++) begin
            do_write(addrs[$urandom_range(0, 4)], {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) tick();
            do_read(addrs[$urandom_range(0, 4)], int'($urandom_range(0, 1)), r1a, r4a);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
